// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory constants, default image and address helpers
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam logic [31:0] IMEM_NOP   = 32'h0000_0000;

  // Default program image; every word not listed is a NOP.
  function automatic logic [31:0] imem_init(input int unsigned idx);
    case (idx)
      0:       return 32'h2001_0005;
      1:       return 32'h2002_000A;
      2:       return 32'h0022_1820;
      3:       return 32'hAC03_0000;
      4:       return 32'h0800_0000;
      default: return IMEM_NOP;
    endcase
  endfunction

  function automatic logic [31:0] imem_word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Widened compare so DEPTH*4 never wraps.
  function automatic logic imem_in_range(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return {2'b00, addr} < limit;
  endfunction

  function automatic logic imem_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// rtl/instruction_memory_if.sv - fetch and load bus between the core/loader and the instruction store
interface instruction_memory_if;
  logic [31:0] address;
  logic [31:0] data;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        fault;

  modport master (
    output address, load_en, load_addr, load_data,
    input  data, fault
  );

  modport slave (
    input  address, load_en, load_addr, load_data,
    output data, fault
  );
endinterface

// File: rtl/imem_addr_check.sv
// rtl/imem_addr_check.sv - decodes a byte address into word index, range and alignment flags
module imem_addr_check
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  output logic          in_range,
  output logic          aligned,
  output logic [IW-1:0] index
);

  assign in_range = imem_in_range(addr, DEPTH);
  assign aligned  = imem_aligned(addr);
  assign index    = addr[IW+1:2];

endmodule

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-organised instruction store with combinational fetch,
// synchronous load port and a registered bad-fetch fault flag
module instruction_memory
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IW        = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  reset,
  instruction_memory_if.slave  bus
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          f_in_range, f_aligned;
  logic [IW-1:0] f_index;
  logic          l_in_range, l_aligned;
  logic [IW-1:0] l_index;
  logic          fault_q;

  imem_addr_check #(.DEPTH(DEPTH)) u_fetch_check (
    .addr     (bus.address),
    .in_range (f_in_range),
    .aligned  (f_aligned),
    .index    (f_index)
  );

  imem_addr_check #(.DEPTH(DEPTH)) u_load_check (
    .addr     (bus.load_addr),
    .in_range (l_in_range),
    .aligned  (l_aligned),
    .index    (l_index)
  );

  // Reset restores the full image, so storage stays in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= imem_init(unsigned'(i));
      end
      fault_q <= 1'b0;
    end else begin
      if (bus.load_en && l_in_range && l_aligned) begin
        mem[l_index] <= bus.load_data;
      end
      fault_q <= !(f_in_range && f_aligned);
    end
  end

  assign bus.data  = f_in_range ? mem[f_index] : IMEM_NOP;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed self-checking bench for instruction_memory
module tb_instruction_memory;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  instruction_memory_if bus ();

  instruction_memory #(.DEPTH(64), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset         = 1'b1;
    bus.address   = 32'd0;
    bus.load_en   = 1'b0;
    bus.load_addr = 32'd0;
    bus.load_data = 32'd0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fault: got %b expected 0", bus.fault);
    end
    checks++;
    if (bus.data !== 32'h2001_0005) begin
      errors++;
      $display("FAIL reset_data: got %h expected 20010005", bus.data);
    end
    reset = 1'b0;
  endtask

  task automatic test_image();
    logic [31:0] addrs [6];
    logic [31:0] exps  [6];
    addrs = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd0};
    exps  = '{32'h2001_0005, 32'h2002_000A, 32'h0022_1820,
              32'hAC03_0000, 32'h0800_0000, 32'h2001_0005};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.address = addrs[i];
      #1;
      checks++;
      if (bus.data !== exps[i]) begin
        errors++;
        $display("FAIL image_read[%0d]: addr %h got %h expected %h", i, addrs[i], bus.data, exps[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    addrs = '{32'd256, 32'hFFFF_FFFC};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.address = addrs[i];
      #1;
      checks++;
      if (bus.data !== 32'h0) begin
        errors++;
        $display("FAIL oor_data[%0d]: got %h expected 00000000", i, bus.data);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.fault !== 1'b1) begin
        errors++;
        $display("FAIL oor_fault[%0d]: got %b expected 1", i, bus.fault);
      end
    end
    @(negedge clk);
    bus.address = 32'd8;
    #1;
    checks++;
    if (bus.data !== 32'h0022_1820) begin
      errors++;
      $display("FAIL back_in_range_data: got %h expected 00221820", bus.data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL back_in_range_fault: got %b expected 0", bus.fault);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    bus.address = 32'd6;
    #1;
    checks++;
    if (bus.data !== 32'h2002_000A) begin
      errors++;
      $display("FAIL misaligned_data: got %h expected 2002000a", bus.data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_fault: got %b expected 1", bus.fault);
    end
    @(negedge clk);
    bus.address = 32'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL aligned_fault_clear: got %b expected 0", bus.fault);
    end
  endtask

  task automatic test_load();
    logic [31:0] raddr [5];
    logic [31:0] rexp  [5];
    @(negedge clk);
    bus.address   = 32'd12;
    bus.load_en   = 1'b1;
    bus.load_addr = 32'd12;
    bus.load_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.data !== 32'hAC03_0000) begin
      errors++;
      $display("FAIL load_before_edge: got %h expected ac030000", bus.data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_after_edge: got %h expected deadbeef", bus.data);
    end
    // Dropped loads: misaligned and out of range.
    @(negedge clk);
    bus.load_addr = 32'd13;
    bus.load_data = 32'h1234_5678;
    @(negedge clk);
    bus.load_addr = 32'd256;
    @(negedge clk);
    // Valid loads at word 5 and the last word.
    bus.load_addr = 32'd20;
    bus.load_data = 32'h1111_1111;
    @(negedge clk);
    bus.load_addr = 32'd252;
    bus.load_data = 32'h2222_2222;
    @(negedge clk);
    bus.load_en = 1'b0;
    raddr = '{32'd12, 32'd13, 32'd16, 32'd20, 32'd252};
    rexp  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0800_0000, 32'h1111_1111, 32'h2222_2222};
    for (int i = 0; i < 5; i++) begin
      bus.address = raddr[i];
      #1;
      checks++;
      if (bus.data !== rexp[i]) begin
        errors++;
        $display("FAIL load_readback[%0d]: addr %h got %h expected %h", i, raddr[i], bus.data, rexp[i]);
      end
    end
    bus.address = 32'd256;
    #1;
    checks++;
    if (bus.data !== 32'h0) begin
      errors++;
      $display("FAIL load_oor_read: got %h expected 00000000", bus.data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.address = 32'd6;
    @(posedge clk);
    #1;
    checks++;
    if (bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_fault: got %b expected 1", bus.fault);
    end
    @(negedge clk);
    bus.address   = 32'd12;
    bus.load_en   = 1'b1;
    bus.load_addr = 32'd12;
    bus.load_data = 32'hCAFE_F00D;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data !== 32'hAC03_0000) begin
      errors++;
      $display("FAIL async_reset_data: got %h expected ac030000", bus.data);
    end
    checks++;
    if (bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_fault: got %b expected 0", bus.fault);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.data !== 32'hAC03_0000) begin
      errors++;
      $display("FAIL load_during_reset: got %h expected ac030000", bus.data);
    end
    @(negedge clk);
    bus.load_en = 1'b0;
    reset       = 1'b0;
    bus.address = 32'd20;
    #1;
    checks++;
    if (bus.data !== 32'h0) begin
      errors++;
      $display("FAIL reset_restore_w5: got %h expected 00000000", bus.data);
    end
    bus.address = 32'd252;
    #1;
    checks++;
    if (bus.data !== 32'h0) begin
      errors++;
      $display("FAIL reset_restore_last: got %h expected 00000000", bus.data);
    end
    bus.address = 32'd12;
    #1;
    checks++;
    if (bus.data !== 32'hAC03_0000) begin
      errors++;
      $display("FAIL reset_restore_w3: got %h expected ac030000", bus.data);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_image();
    test_out_of_range();
    test_misaligned();
    test_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
